// File: rtl/seven_segment_scanner_if.sv
// Pin-level bus between the numeric datapath (master) and the seven-segment scanner (slave).
// Parameter DIGITS must match the scanner instance it is connected to.
interface seven_segment_scanner_if #(
  parameter int DIGITS = 4
);
  // No valid/ready here: number/dots/digit_en are level signals the scanner samples
  // once per frame at frame_start; the display outputs are free-running pin levels.
  logic [4*DIGITS-1:0] number;
  logic [DIGITS-1:0]   dots;
  logic [DIGITS-1:0]   digit_en;
  logic [6:0]          gfedcba;
  logic                dp_n;
  logic [DIGITS-1:0]   anode_n;
  logic                frame_start;

  modport master (
    output number,
    output dots,
    output digit_en,
    input  gfedcba,
    input  dp_n,
    input  anode_n,
    input  frame_start
  );

  modport slave (
    input  number,
    input  dots,
    input  digit_en,
    output gfedcba,
    output dp_n,
    output anode_n,
    output frame_start
  );
endinterface

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed common-anode seven-segment scanner with per-frame snapshot and blanking gaps.
// Optional leading-zero suppression: define SEVEN_SEGMENT_SCANNER_LEADING_ZERO_BLANK_EN.
module seven_segment_scanner #(
  parameter int DIGITS       = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                      clk,
  input  logic                      rst_n,
  seven_segment_scanner_if.slave    io_bus,
  output logic                      o_dbg_state,
  output logic [$clog2(DIGITS)-1:0] o_dbg_index
);

  localparam int CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = $clog2(DIGITS);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  logic [0:0]          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [4*DIGITS-1:0] r_snap_num;
  logic [DIGITS-1:0]   r_snap_dots;
  logic [DIGITS-1:0]   r_snap_en;
  logic [6:0]          r_seg;
  logic                r_dp_n;
  logic [DIGITS-1:0]   r_anode_n;
  logic                r_frame_start;

  logic                w_blank_done;
  logic                w_show_done;
  logic                w_new_frame;
  logic [DIGITS-1:0]   w_lead_sup;
  logic [4*DIGITS-1:0] w_num_src;
  logic [DIGITS-1:0]   w_dots_src;
  logic [DIGITS-1:0]   w_en_src;
  logic [3:0]          w_nibble;
  logic                w_dig_on;
  logic                w_dot_on;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_to_seg = 7'b1000000;
      4'h1:    hex_to_seg = 7'b1111001;
      4'h2:    hex_to_seg = 7'b0100100;
      4'h3:    hex_to_seg = 7'b0110000;
      4'h4:    hex_to_seg = 7'b0011001;
      4'h5:    hex_to_seg = 7'b0010010;
      4'h6:    hex_to_seg = 7'b0000010;
      4'h7:    hex_to_seg = 7'b1111000;
      4'h8:    hex_to_seg = 7'b0000000;
      4'h9:    hex_to_seg = 7'b0011000;
      4'hA:    hex_to_seg = 7'b0001000;
      4'hB:    hex_to_seg = 7'b0000011;
      4'hC:    hex_to_seg = 7'b1000110;
      4'hD:    hex_to_seg = 7'b0100001;
      4'hE:    hex_to_seg = 7'b0000110;
      default: hex_to_seg = 7'b0001110;
    endcase
  endfunction

  assign w_blank_done = (r_state == ST_BLANK) && (r_cnt == BLANK_LAST);
  assign w_show_done  = (r_state == ST_SHOW)  && (r_cnt == SHOW_LAST);
  assign w_new_frame  = w_blank_done && (r_idx == '0);

`ifdef SEVEN_SEGMENT_SCANNER_LEADING_ZERO_BLANK_EN
  // Walk from the top digit down; suppress until a nonzero nibble or a dot is seen.
  always_comb begin
    logic seen;
    seen       = 1'b0;
    w_lead_sup = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      seen          = seen | (io_bus.number[4*i +: 4] != 4'h0) | io_bus.dots[i];
      w_lead_sup[i] = ~seen;
    end
  end
`else
  assign w_lead_sup = '0;
`endif

  // Digit 0's slot decodes from the live inputs because the snapshot loads on the same edge.
  assign w_num_src  = w_new_frame ? io_bus.number : r_snap_num;
  assign w_dots_src = w_new_frame ? io_bus.dots : r_snap_dots;
  assign w_en_src   = w_new_frame ? (io_bus.digit_en & ~w_lead_sup) : r_snap_en;
  assign w_nibble   = w_num_src[{r_idx, 2'b00} +: 4];
  assign w_dig_on   = w_en_src[r_idx];
  assign w_dot_on   = w_dots_src[r_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_BLANK;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_snap_num    <= '0;
      r_snap_dots   <= '0;
      r_snap_en     <= '0;
      r_seg         <= 7'h7F;
      r_dp_n        <= 1'b1;
      r_anode_n     <= '1;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      if (w_blank_done) begin
        r_state   <= ST_SHOW;
        r_cnt     <= '0;
        r_anode_n <= w_dig_on ? ~(DIGITS'(1) << r_idx) : '1;
        r_seg     <= w_dig_on ? hex_to_seg(w_nibble) : 7'h7F;
        r_dp_n    <= ~(w_dig_on & w_dot_on);
        if (w_new_frame) begin
          r_snap_num    <= w_num_src;
          r_snap_dots   <= w_dots_src;
          r_snap_en     <= w_en_src;
          r_frame_start <= 1'b1;
        end
      end else if (w_show_done) begin
        r_state   <= ST_BLANK;
        r_cnt     <= '0;
        r_idx     <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
        r_anode_n <= '1;
        r_seg     <= 7'h7F;
        r_dp_n    <= 1'b1;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign io_bus.gfedcba     = r_seg;
  assign io_bus.dp_n        = r_dp_n;
  assign io_bus.anode_n     = r_anode_n;
  assign io_bus.frame_start = r_frame_start;
  assign o_dbg_state        = r_state;
  assign o_dbg_index        = r_idx;

  a_anode_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(~r_anode_n));

  a_blank_dark: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == ST_BLANK) |-> ((r_anode_n == '1) && (r_seg == 7'h7F) && r_dp_n));

  a_frame_start_slot0: assert property (@(posedge clk) disable iff (!rst_n)
    r_frame_start |-> ((r_state == ST_SHOW) && (r_idx == '0) && (r_cnt == '0)));

endmodule

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
Time-multiplexed scan controller for a common-anode seven-segment display bank of DIGITS digits. One hex-to-segment decoder is shared across all digits; the block walks a digit index, selects one nibble per slot, drives active-low segments and active-low anode selects, and inserts blanking gaps against ghosting. Values are snapshotted once per frame so the display never tears. It sits between the numeric datapath and the board display pins.

Parameters:
DIGITS, 4, number of digits scanned (2..8)
CLK_DIV, 50000, clk cycles a digit is lit per slot (>=1)
BLANK_CYCLES, 500, clk cycles all anodes are off between slots (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active low
number  in  4*DIGITS  hex value; digit i = number[4i+3:4i]
dots  in  DIGITS  decimal point request per digit
digit_en  in  DIGITS  per-digit enable
gfedcba  out  7  segments g..a, active low (0 = lit)
dp_n  out  1  decimal point, active low
anode_n  out  DIGITS  digit select, one-hot active low
frame_start  out  1  one-cycle pulse when digit 0 slot begins

Behaviour:
- Reset (asynchronous, immediate): anode_n all 1, gfedcba 7'b1111111, dp_n 1, frame_start 0, state BLANK, index 0, counter 0, snapshot cleared (all digits disabled).
- FSM, two states, one down/up counter sized $clog2 of max(CLK_DIV, BLANK_CYCLES):
  - BLANK: anode_n all 1, segments 1111111, dp_n 1. After BLANK_CYCLES cycles -> SHOW.
  - SHOW: anode_n[index] = 0 if the digit is enabled, else all 1. After CLK_DIV cycles -> BLANK, index increments, wrapping DIGITS-1 -> 0.
- Snapshot: on the BLANK->SHOW edge with index 0, number/dots/digit_en are latched into internal registers; frame_start is 1 for exactly that following cycle. All digits of a frame use the snapshot. Input changes appear at the next frame start; latency is at most one frame.
- Segment decode: combinational hex decode of the snapshot nibble at index. Encoding is 0:1000000 1:1111001 2:0100100 3:0110000 4:0011001 5:0010010 6:0000010 7:1111000 8:0000000 9:0011000 A:0001000 b:0000011 C:1000110 d:0100001 E:0000110 F:0001110. The result is registered on the BLANK->SHOW edge, so gfedcba, dp_n and anode_n change on the same clock edge. dp_n = ~dots_snapshot[index].
- Disabled digit: its slot is still consumed, so frame timing stays constant. anode_n stays all 1 and segments stay 1111111.
- Frame length is always DIGITS*(CLK_DIV+BLANK_CYCLES) cycles.
- After reset release: BLANK_CYCLES blank cycles, then SHOW for index 0, with snapshot and frame_start.
- No two anodes are ever low in the same cycle.

Optional Feature:
SEVEN_SEGMENT_SCANNER_LEADING_ZERO_BLANK_EN.
- Defined: at snapshot, digits are scanned from DIGITS-1 downward. Each digit whose nibble is 0 and whose dot is 0 is suppressed (treated as disabled) until the first digit that is nonzero or has its dot set. Digit 0 is never suppressed.
- Undefined: every enabled digit is shown, including leading zeros.
- Timing is identical in both builds.

Test Plan:
(All with DIGITS=4, CLK_DIV=4, BLANK_CYCLES=2.)
1. Reset, number=16'h1234, digit_en=4'hF, dots=0 -> anode_n cycles 1110,1101,1011,0111, each low for 4 cycles with 2 cycles of 1111 between. gfedcba = 0011001, 0110000, 0100100, 1111001. frame_start pulses every 24 cycles.
2. Change number to 16'hABCD during the digit 1 slot -> digits 2 and 3 still show 2 and 1. Next frame digit 0 shows 0100001 (d) and digit 3 shows 0001000 (A).
3. digit_en=4'b0101 -> anode_n[1] and anode_n[3] never 0. Segments are 1111111 in those slots. frame_start period remains 24.
4. dots=4'b0010 -> dp_n=0 only while anode_n=1101; dp_n=1 at all other times, including blank gaps.
5. Drive rst_n low mid-SHOW -> same cycle anode_n=1111, gfedcba=1111111, dp_n=1. On release, 2 blank cycles, then digit 0 with frame_start=1.
6. Macro defined, number=16'h0050 -> digits 3 and 2 dark, digit 1=0010010, digit 0=1000000. number=0 -> only digit 0 lit with 1000000. number=16'h0050 with dots=4'b0100 -> digit 2 lit with 1000000 and dp_n=0.
